// File: rtl/node_table_writer.sv
`default_nettype none
// ============================================================================
// Module   : node_table_writer
// Purpose  : Streams a block of host node words into the node-table SRAM.
//            A start request latches a base address and word count. Each
//            accepted host word is written one cycle later at consecutive
//            addresses that wrap modulo 2^ADDR_WIDTH. done_o pulses together
//            with the final write.
// Ports    :
//   clk, rst_n                   clock, asynchronous active-low reset
//   start_i                      begin a load (sampled only in IDLE)
//   baseAddr_i, wordCount_i      load parameters, sampled with start_i
//   abort_i                      terminate a load in progress
//   dataValid_i, data_i          host word stream
//   dataReady_o                  writer accepts a word this cycle
//   sramWe_o/Addr_o/Data_o       SRAM write port (one word per We cycle)
//   busy_o                       load in progress (LOAD or FLUSH)
//   done_o                       one-cycle completion pulse
//   overflow_o                   sticky: address wrapped during the load
// Revision : 1.0 - initial release
// ============================================================================
module node_table_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] baseAddr_i,
  input  logic [ADDR_WIDTH:0]   wordCount_i,
  input  logic                  abort_i,
  input  logic                  dataValid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  dataReady_o,
  output logic                  sramWe_o,
  output logic [ADDR_WIDTH-1:0] sramAddr_o,
  output logic [DATA_WIDTH-1:0] sramData_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_addr, wr_addr_nxt;
  logic [ADDR_WIDTH:0]     remaining, remaining_nxt;
  logic                    ready_nxt, we_nxt, busy_nxt, done_nxt, ovf_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    accept;

  // Abort discards a handshake that coincides with it; dataReady_o itself
  // stays a pure register output.
  assign accept = (state == LOAD) && dataValid_i && dataReady_o && !abort_i;

  always_comb begin
    state_nxt     = state;
    wr_addr_nxt   = wr_addr;
    remaining_nxt = remaining;
    ready_nxt     = 1'b0;
    we_nxt        = 1'b0;
    addr_nxt      = sramAddr_o;
    data_nxt      = sramData_o;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    ovf_nxt       = overflow_o;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          ovf_nxt = 1'b0;
          if (wordCount_i != '0) begin
            wr_addr_nxt   = baseAddr_i;
            remaining_nxt = wordCount_i;
            state_nxt     = LOAD;
            ready_nxt     = 1'b1;
            busy_nxt      = 1'b1;
          end else begin
            // Empty load completes immediately without touching the SRAM.
            done_nxt = 1'b1;
          end
        end
      end

      LOAD: begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b1;
        if (abort_i) begin
          state_nxt     = IDLE;
          ready_nxt     = 1'b0;
          busy_nxt      = 1'b0;
          remaining_nxt = '0;
        end else if (accept) begin
          we_nxt        = 1'b1;
          addr_nxt      = wr_addr;
          data_nxt      = data_i;
          wr_addr_nxt   = wr_addr + ADDR_ONE;
          remaining_nxt = remaining - CNT_ONE;
          if (wr_addr == ADDR_MAX) begin
            ovf_nxt = 1'b1;
          end
          if (remaining == CNT_ONE) begin
            // Final write and done_o appear together in the FLUSH cycle.
            state_nxt = FLUSH;
            ready_nxt = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end

      FLUSH: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_addr     <= '0;
      remaining   <= '0;
      dataReady_o <= 1'b0;
      sramWe_o    <= 1'b0;
      sramAddr_o  <= '0;
      sramData_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_addr     <= wr_addr_nxt;
      remaining   <= remaining_nxt;
      dataReady_o <= ready_nxt;
      sramWe_o    <= we_nxt;
      sramAddr_o  <= addr_nxt;
      sramData_o  <= data_nxt;
      busy_o      <= busy_nxt;
      done_o      <= done_nxt;
      overflow_o  <= ovf_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_node_table_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_node_table_writer
// Purpose  : Directed self-checking bench for node_table_writer. A monitor
//            logs every SRAM write and done pulse with its cycle number; each
//            scenario task drives a load and compares the log against
//            hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_node_table_writer;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] baseAddr_i;
  logic [AW:0]   wordCount_i;
  logic          abort_i;
  logic          dataValid_i;
  logic [DW-1:0] data_i;
  logic          dataReady_o;
  logic          sramWe_o;
  logic [AW-1:0] sramAddr_o;
  logic [DW-1:0] sramData_o;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;

  node_table_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .baseAddr_i(baseAddr_i),
    .wordCount_i(wordCount_i), .abort_i(abort_i), .dataValid_i(dataValid_i),
    .data_i(data_i), .dataReady_o(dataReady_o), .sramWe_o(sramWe_o),
    .sramAddr_o(sramAddr_o), .sramData_o(sramData_o), .busy_o(busy_o),
    .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Write / done log, sampled on the falling edge.
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int            wc[$];
  int            cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            done_with_we = 0;
  bit            busy_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (sramWe_o) begin
      wa.push_back(sramAddr_o);
      wd.push_back(sramData_o);
      wc.push_back(cyc);
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      if (sramWe_o) done_with_we++;
    end
    if (busy_o) busy_seen = 1;
  end

  task automatic clear_log();
    #1;
    wa.delete(); wd.delete(); wc.delete();
    done_cnt = 0; done_cyc = -1; done_with_we = 0; busy_seen = 0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; leaves start_i low at the next falling edge.
  task automatic start_load(logic [AW-1:0] base, logic [AW:0] count);
    start_i = 1'b1; baseAddr_i = base; wordCount_i = count;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Offers n words d0, d0+1, ...; gap=1 toggles valid 1,0,1,0.
  // With abort_after>=0, abort_i is raised (with a live valid word) once
  // that many words have been accepted.
  task automatic pump(int n, logic [DW-1:0] d0, bit gap, int abort_after);
    int  sent = 0;
    int  c = 0;
    bit  ph = 1'b1;
    while (sent < n && c < 200) begin
      if (abort_after >= 0 && sent == abort_after) begin
        abort_i = 1'b1; dataValid_i = 1'b1; data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        abort_i = 1'b0;
        break;
      end
      dataValid_i = ph;
      data_i      = d0 + DW'(sent);
      if (ph && dataReady_o) sent++;
      @(negedge clk);
      c++;
      if (gap) ph = ~ph;
    end
    dataValid_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (dataReady_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", dataReady_o); end
    checks++; if (sramWe_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", sramWe_o); end
    checks++; if (sramAddr_o !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", sramAddr_o); end
    checks++; if (sramData_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", sramData_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow_o); end
  endtask

  task automatic test_basic();
    clear_log();
    start_load(10'h010, 11'd4);
    checks++; if (dataReady_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL basic_enter_load ready %b busy %b exp 1 1", dataReady_o, busy_o); end
    // A second start during the load must be ignored.
    start_i = 1'b1; baseAddr_i = 10'h300; wordCount_i = 11'd9;
    pump(4, 32'hA0, 1'b0, -1);
    start_i = 1'b0;
    idle(4);
    checks++; if (wa.size() != 4) begin errors++; $display("FAIL basic_nwrites got %0d exp 4", wa.size()); end
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      checks++; if (wa[i] !== AW'(16 + i) || wd[i] !== DW'(32'hA0 + i)) begin errors++; $display("FAIL basic_write%0d got %h/%h exp %h/%h", i, wa[i], wd[i], 16 + i, 32'hA0 + i); end
    end
    checks++; if (wa.size() == 4 && wc[3] - wc[0] != 3) begin errors++; $display("FAIL basic_consecutive span %0d exp 3", wc[3] - wc[0]); end
    checks++; if (done_cnt != 1 || done_with_we != 1) begin errors++; $display("FAIL basic_done pulses %0d with_we %0d exp 1 1", done_cnt, done_with_we); end
    checks++; if (busy_o !== 1'b0 || sramWe_o !== 1'b0) begin errors++; $display("FAIL basic_idle busy %b we %b exp 0 0", busy_o, sramWe_o); end
    checks++; if (sramAddr_o !== 10'h013 || sramData_o !== 32'hA3) begin errors++; $display("FAIL basic_hold got %h/%h exp 013/a3", sramAddr_o, sramData_o); end
  endtask

  task automatic test_gaps();
    clear_log();
    start_load(10'h010, 11'd4);
    pump(4, 32'hA0, 1'b1, -1);
    idle(4);
    checks++; if (wa.size() != 4) begin errors++; $display("FAIL gaps_nwrites got %0d exp 4", wa.size()); end
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      checks++; if (wa[i] !== AW'(16 + i) || wd[i] !== DW'(32'hA0 + i)) begin errors++; $display("FAIL gaps_write%0d got %h/%h exp %h/%h", i, wa[i], wd[i], 16 + i, 32'hA0 + i); end
    end
    for (int i = 1; i < 4 && i < wc.size(); i++) begin
      checks++; if (wc[i] - wc[i-1] != 2) begin errors++; $display("FAIL gaps_spacing%0d got %0d exp 2", i, wc[i] - wc[i-1]); end
    end
    checks++; if (wc.size() == 4 && (done_cnt != 1 || done_cyc != wc[3])) begin errors++; $display("FAIL gaps_done count %0d cyc %0d exp 1 %0d", done_cnt, done_cyc, wc[3]); end
  endtask

  task automatic test_wrap();
    clear_log();
    start_load(10'h3FE, 11'd3);
    pump(3, 32'hB0, 1'b0, -1);
    idle(3);
    checks++; if (wa.size() != 3) begin errors++; $display("FAIL wrap_nwrites got %0d exp 3", wa.size()); end
    if (wa.size() == 3) begin
      checks++; if (wa[0] !== 10'h3FE || wa[1] !== 10'h3FF || wa[2] !== 10'h000) begin errors++; $display("FAIL wrap_addrs got %h %h %h exp 3fe 3ff 000", wa[0], wa[1], wa[2]); end
    end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL wrap_ovf_set got %b exp 1", overflow_o); end
  endtask

  // Runs right after test_wrap so the start also clears the sticky overflow.
  task automatic test_zero_count();
    clear_log();
    start_load(10'h123, 11'd0);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL zero_ovf_clear got %b exp 0", overflow_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b exp 0", done_o); end
    idle(2);
    checks++; if (wa.size() != 0 || busy_seen) begin errors++; $display("FAIL zero_quiet writes %0d busy_seen %b exp 0 0", wa.size(), busy_seen); end
  endtask

  task automatic test_abort();
    clear_log();
    start_load(10'h100, 11'd5);
    pump(5, 32'hC0, 1'b0, 2);
    checks++; if (busy_o !== 1'b0 || dataReady_o !== 1'b0) begin errors++; $display("FAIL abort_idle busy %b ready %b exp 0 0", busy_o, dataReady_o); end
    // Keep offering words: they must not be taken.
    dataValid_i = 1'b1; data_i = 32'h55;
    idle(3);
    dataValid_i = 1'b0;
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL abort_nwrites got %0d exp 2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wa[0] !== 10'h100 || wd[0] !== 32'hC0 || wa[1] !== 10'h101 || wd[1] !== 32'hC1) begin errors++; $display("FAIL abort_writes got %h/%h %h/%h exp 100/c0 101/c1", wa[0], wd[0], wa[1], wd[1]); end
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt); end
    clear_log();
    start_load(10'h200, 11'd1);
    pump(1, 32'hD0, 1'b0, -1);
    idle(3);
    checks++; if (wa.size() != 1 || done_cnt != 1) begin errors++; $display("FAIL after_abort_load writes %0d done %0d exp 1 1", wa.size(), done_cnt); end
    if (wa.size() == 1) begin
      checks++; if (wa[0] !== 10'h200 || wd[0] !== 32'hD0) begin errors++; $display("FAIL after_abort_write got %h/%h exp 200/d0", wa[0], wd[0]); end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    start_load(10'h050, 11'd3);
    pump(1, 32'hE0, 1'b0, -1);
    // The first write is on the bus now; reset must clear it at once.
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dataReady_o, sramWe_o, busy_o, done_o, overflow_o} !== 5'b0 || sramAddr_o !== '0 || sramData_o !== '0) begin
      errors++; $display("FAIL midreset_outputs rdy %b we %b busy %b done %b ovf %b addr %h data %h exp all 0", dataReady_o, sramWe_o, busy_o, done_o, overflow_o, sramAddr_o, sramData_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    dataValid_i = 1'b1; data_i = 32'hE1;
    idle(4);
    dataValid_i = 1'b0;
    checks++; if (wa.size() != 0 || done_cnt != 0 || busy_seen) begin errors++; $display("FAIL midreset_quiet writes %0d done %0d busy_seen %b exp 0 0 0", wa.size(), done_cnt, busy_seen); end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; baseAddr_i = '0; wordCount_i = '0;
    abort_i = 1'b0; dataValid_i = 1'b0; data_i = '0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_zero_count();
    test_abort();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a scenario stalls.
  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/node_table_writer.md
NODE_TABLE_WRITER -- requirements
Module: node_table_writer

Interface
REQ-001 Parameter: ADDR_WIDTH, default 10, SRAM node-table address width.
REQ-002 Parameter: DATA_WIDTH, default 32, SRAM node word width (threshold/index word read by node logic).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start_i  input  1  single-cycle request to begin a table load.
REQ-006 Port: baseAddr_i  input  ADDR_WIDTH  first SRAM address of the load; sampled with start_i.
REQ-007 Port: wordCount_i  input  ADDR_WIDTH+1  number of words to write; sampled with start_i.
REQ-008 Port: abort_i  input  1  terminate the load in progress.
REQ-009 Port: dataValid_i  input  1  host word valid.
REQ-010 Port: data_i  input  DATA_WIDTH  host node word.
REQ-011 Port: dataReady_o  output  1  writer can accept a word this cycle.
REQ-012 Port: sramWe_o  output  1  SRAM write enable, one word per asserted cycle.
REQ-013 Port: sramAddr_o  output  ADDR_WIDTH  SRAM write address.
REQ-014 Port: sramData_o  output  DATA_WIDTH  SRAM write data.
REQ-015 Port: busy_o  output  1  load in progress (state LOAD or FLUSH).
REQ-016 Port: done_o  output  1  one-cycle pulse on load completion.
REQ-017 Port: overflow_o  output  1  sticky flag: address wrapped during current/last load.

Function
REQ-018 FSM states: IDLE, LOAD, FLUSH; all outputs registered.
REQ-019 IDLE: dataReady_o=0, busy_o=0; start_i=1 with wordCount_i>0 -> latch base/count, clear overflow_o, enter LOAD next cycle.
REQ-020 IDLE: start_i=1 with wordCount_i=0 -> done_o=1 for exactly one cycle next cycle, no SRAM write, stay IDLE, overflow_o cleared.
REQ-021 LOAD: dataReady_o=1; handshake = dataValid_i & dataReady_o in same cycle; data_i ignored otherwise.
REQ-022 Each accepted word -> sramWe_o=1 on the next cycle with sramData_o=that word and sramAddr_o=current write address; latency exactly 1 cycle.
REQ-023 Write address starts at baseAddr_i, increments by 1 per accepted word, modulo 2^ADDR_WIDTH.
REQ-024 Increment from 2^ADDR_WIDTH-1 to 0 sets overflow_o=1; remains set until next accepted start_i or reset.
REQ-025 Remaining-word counter decrements per accepted word; acceptance of the last word -> FLUSH next cycle, dataReady_o=0 in that cycle.
REQ-026 FLUSH: last write is issued (sramWe_o=1); done_o=1 in the same cycle; next state IDLE. Lasts exactly 1 cycle.
REQ-027 Back-to-back valid: one word per cycle sustained, no bubbles.
REQ-028 start_i in LOAD or FLUSH ignored; no relatch.
REQ-029 abort_i in LOAD: return to IDLE next cycle, no done_o; a word accepted in the abort cycle is not accepted (abort wins, dataReady_o effectively masked by abort_i combinationally not allowed -- abort_i simply discards that handshake); a write already registered from the previous cycle still completes.
REQ-030 abort_i in IDLE or FLUSH: no effect.
REQ-031 sramAddr_o/sramData_o hold last values when sramWe_o=0.

Reset
REQ-032 rst_n low asynchronously forces IDLE, dataReady_o=0, sramWe_o=0, sramAddr_o=0, sramData_o=0, busy_o=0, done_o=0, overflow_o=0, counters 0.
REQ-033 Reset mid-LOAD or mid-FLUSH drops any pending write and done pulse; after release the block waits in IDLE for start_i.

Verification
REQ-034 start_i, baseAddr_i=0x010, wordCount_i=4, valid every cycle with 0xA0..0xA3 -> sramWe_o on 4 consecutive cycles at 0x010..0x013 with data 0xA0..0xA3, done_o with last write, busy_o low after.
REQ-035 Same load, dataValid_i toggling 1,0,1,0 -> writes only one cycle after each accepted word, addresses contiguous, done_o after 4th write.
REQ-036 baseAddr_i=0x3FE, wordCount_i=3 -> writes at 0x3FE, 0x3FF, 0x000; overflow_o=1 from wrap, cleared by next start_i.
REQ-037 wordCount_i=0 -> done_o one-cycle pulse, sramWe_o never asserted, busy_o stays 0.
REQ-038 Abort after 2 of 5 words -> exactly 2 writes, no done_o, IDLE; subsequent start_i, count 1 completes normally.
REQ-039 rst_n low during LOAD after 1 of 3 words -> all outputs 0 immediately; no further writes or done_o after release.
